ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the RAM address width (64 words).
REQ-002 Parameter DATA_W, default 16, SHALL set the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wr_req  input  1  SHALL be the write request, held high until wr_grant is seen.
REQ-006 wr_addr  input  ADDR_W  SHALL be the write address, stable while wr_req is high.
REQ-007 wr_data  input  DATA_W  SHALL be the write data, stable while wr_req is high.
REQ-008 wr_grant  output  1  SHALL pulse for one cycle when the write is issued to the RAM.
REQ-009 rd_req  input  1  SHALL be the read request, held high until rd_grant is seen.
REQ-010 rd_addr  input  ADDR_W  SHALL be the read address, stable while rd_req is high.
REQ-011 rd_grant  output  1  SHALL pulse for one cycle when the read is issued to the RAM.
REQ-012 rd_valid  output  1  SHALL pulse for one cycle when rd_data holds the fetched word.
REQ-013 rd_data  output  DATA_W  SHALL hold the last fetched word until the next rd_valid.
REQ-014 ram_addr  output  ADDR_W  SHALL be the address to the single-port RAM.
REQ-015 ram_we  output  1  SHALL be the one-cycle RAM write strobe.
REQ-016 ram_re  output  1  SHALL be the one-cycle RAM read enable.
REQ-017 ram_wdata  output  DATA_W  SHALL be the data to the RAM.
REQ-018 ram_rdata  input  DATA_W  SHALL be valid one cycle after ram_re (one-cycle RAM latency).

Function
REQ-019 FSM states: IDLE, GNT_WR, GNT_RD, RD_CAP. All outputs SHALL be registered.
REQ-020 IDLE: the FSM samples the requests. wr_req only -> GNT_WR; rd_req only -> GNT_RD; neither -> IDLE.
REQ-021 Both requests in IDLE: the requester not granted last SHALL win (round-robin). last_grant SHALL update on every grant.
REQ-022 GNT_WR (one cycle): ram_we=1, wr_grant=1, ram_addr=wr_addr and ram_wdata=wr_data latched at the IDLE edge. The FSM SHALL then go to IDLE.
REQ-023 GNT_RD (one cycle): ram_re=1, rd_grant=1, ram_addr=rd_addr latched at the IDLE edge. The FSM SHALL then go to RD_CAP.
REQ-024 RD_CAP (one cycle): rd_data SHALL capture ram_rdata. rd_valid SHALL be 1 in the following cycle, which is in IDLE.
REQ-025 Latency: a write SHALL be issued 1 cycle after the request is sampled. A read SHALL return rd_valid 3 cycles after the request is sampled.
REQ-026 Throughput: at most one RAM access every 2 cycles for writes and every 3 cycles for reads. ram_we and ram_re SHALL never both be high.
REQ-027 Requesters SHALL drop the request in the cycle after its grant. A request still high in IDLE SHALL be treated as a new request.
REQ-028 ram_wdata SHALL hold its last value and ram_addr SHALL hold its last value outside grant cycles.
REQ-029 Address arithmetic: addresses pass through unmodified. There is no wrap or increment inside this block.

Reset
REQ-030 On reset: state=IDLE; wr_grant, rd_grant, rd_valid, ram_we, ram_re = 0; ram_addr, ram_wdata, rd_data = 0; last_grant=read, so write wins the first tie.
REQ-031 Reset in GNT_RD or RD_CAP SHALL abort the read, with no rd_valid pulse afterwards.
REQ-032 Reset in GNT_WR SHALL deassert ram_we in the next cycle.

Structure
REQ-033 A shared package SHALL hold the state enum, the ADDR_W/DATA_W defaults and the grant-owner encoding (WR=0, RD=1).
REQ-034 No sub-module is needed: the round-robin pick and the FSM SHALL be inline in ram_port_arbiter.

Verification
REQ-035 Write only: wr_req, addr 0x05, data 0x0ABC -> next cycle ram_we=1, ram_addr=0x05, ram_wdata=0x0ABC, wr_grant=1, for one cycle.
REQ-036 Read after write: rd_req, addr 0x05, with the RAM model returning 0x0ABC -> rd_grant one cycle later, rd_valid with rd_data=0x0ABC 3 cycles after sampling.
REQ-037 Tie after reset: wr_req and rd_req high together -> write granted first, then read. A second tie with the write last -> read granted first.
REQ-038 Sustained contention: both requests re-asserted for 8 grants -> grants alternate WR, RD, WR, RD, and ram_we and ram_re are never high together.
REQ-039 Reset mid-read: reset asserted in RD_CAP -> rd_valid stays 0, all outputs 0, and the FSM is in IDLE the next cycle.
REQ-040 Boundary address: read at 0x3F -> ram_addr=0x3F, with no wrap to 0x00.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester single-port RAM arbiter.
// Holds the FSM state encoding, default widths and grant-owner encoding.
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_WR = 2'd1,
        GNT_RD = 2'd2,
        RD_CAP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } owner_e;

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a write and a read
// requester; every output comes straight from a register.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q;
    owner_e            last_q;
    logic              wr_grant_q;
    logic              rd_grant_q;
    logic              rd_valid_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] rd_data_q;

    logic pick_wr_d;
    logic pick_rd_d;

    // On a tie the side that did not win last time goes next.
    assign pick_wr_d = wr_req & (~rd_req | (last_q == OWN_RD));
    assign pick_rd_d = rd_req & ~pick_wr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= OWN_RD;
            wr_grant_q  <= 1'b0;
            rd_grant_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            rd_valid_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    unique case (1'b1)
                        pick_wr_d: begin
                            state_q     <= GNT_WR;
                            last_q      <= OWN_WR;
                            wr_grant_q  <= 1'b1;
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= wr_addr;
                            ram_wdata_q <= wr_data;
                        end
                        pick_rd_d: begin
                            state_q    <= GNT_RD;
                            last_q     <= OWN_RD;
                            rd_grant_q <= 1'b1;
                            ram_re_q   <= 1'b1;
                            ram_addr_q <= rd_addr;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
                GNT_WR: state_q <= IDLE;
                GNT_RD: state_q <= RD_CAP;
                RD_CAP: begin
                    // RAM word is valid now, one cycle after ram_re.
                    rd_data_q  <= ram_rdata;
                    rd_valid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM,
// a shadow memory model and a read-data scoreboard.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_grant;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_grant;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem   [0:63];
    logic [DW-1:0] model [0:63];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_e;
    owner_e        exp_last;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grant(wr_grant),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (ram_we && ram_re) begin
                errors++;
                $display("FAIL we_re_excl: ram_we=%b ram_re=%b, required not both 1",
                         ram_we, ram_re);
            end
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_valid_unexpected: rd_data=%h, no read outstanding",
                             rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rd_data !== mon_e) begin
                        errors++;
                        $display("FAIL sb_rd_data: got %h expected %h", rd_data, mon_e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_grant, rd_grant, rd_valid, ram_we, ram_re} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {wr_grant, rd_grant, rd_valid, ram_we, ram_re});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0",
                     ram_addr, ram_wdata, rd_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
        end
        reset = 1'b0;
        exp_last = OWN_RD;
    endtask

    task automatic test_write_only();
        wr_req = 1'b1; wr_addr = 6'h05; wr_data = 16'h0ABC;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || wr_grant !== 1'b1 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe: we=%b gnt=%b re=%b expected 1 1 0",
                     ram_we, wr_grant, ram_re);
        end
        checks++;
        if (ram_addr !== 6'h05 || ram_wdata !== 16'h0ABC) begin
            errors++;
            $display("FAIL wr_bus: addr=%h wdata=%h expected 05 0abc",
                     ram_addr, ram_wdata);
        end
        model[5] = 16'h0ABC;
        exp_last = OWN_WR;
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || wr_grant !== 1'b0) begin
            errors++;
            $display("FAIL wr_one_cycle: we=%b gnt=%b expected 0 0", ram_we, wr_grant);
        end
        checks++;
        if (ram_addr !== 6'h05 || ram_wdata !== 16'h0ABC) begin
            errors++;
            $display("FAIL wr_hold: addr=%h wdata=%h expected 05 0abc",
                     ram_addr, ram_wdata);
        end
    endtask

    task automatic test_read_after_write();
        rd_req = 1'b1; rd_addr = 6'h05;
        @(negedge clk);
        checks++;
        if (rd_grant !== 1'b1 || ram_re !== 1'b1 || ram_addr !== 6'h05) begin
            errors++;
            $display("FAIL rd_grant: gnt=%b re=%b addr=%h expected 1 1 05",
                     rd_grant, ram_re, ram_addr);
        end
        exp_q.push_back(model[5]);
        exp_last = OWN_RD;
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_grant !== 1'b0) begin
            errors++;
            $display("FAIL rd_cap: valid=%b gnt=%b expected 0 0", rd_valid, rd_grant);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0ABC) begin
            errors++;
            $display("FAIL rd_latency: valid=%b data=%h expected 1 0abc",
                     rd_valid, rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0ABC) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%h expected 0 0abc",
                     rd_valid, rd_data);
        end
    endtask

    task automatic lone_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int cyc = 0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_grant && cyc < 10);
        checks++;
        if (!wr_grant || ram_addr !== a || ram_wdata !== d) begin
            errors++;
            $display("FAIL lone_write: gnt=%b addr=%h wdata=%h expected 1 %h %h",
                     wr_grant, ram_addr, ram_wdata, a, d);
        end
        model[a] = d;
        exp_last = OWN_WR;
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_contention(input int n, input logic [AW-1:0] wa,
                                  input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                                  input string tag);
        int got = 0;
        int cyc = 0;
        owner_e exp_o;
        owner_e obs;
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = wa; wr_data = wd; rd_addr = ra;
        while (got < n && cyc < 20 * n) begin
            @(negedge clk);
            cyc++;
            if (wr_grant || rd_grant) begin
                exp_o = (exp_last == OWN_RD) ? OWN_WR : OWN_RD;
                obs   = wr_grant ? OWN_WR : OWN_RD;
                checks++;
                if (obs !== exp_o || (wr_grant && rd_grant)) begin
                    errors++;
                    $display("FAIL %s_order: grant %0d wr=%b rd=%b expected owner %s",
                             tag, got, wr_grant, rd_grant,
                             exp_o == OWN_WR ? "WR" : "RD");
                end
                if (exp_o == OWN_WR) model[wa] = wd;
                else exp_q.push_back(model[ra]);
                exp_last = exp_o;
                got++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d grants expected %0d", tag, got, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tie();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_last = OWN_RD;
        run_contention(2, 6'h10, 16'h1234, 6'h05, "tie_reset");
        lone_write(6'h11, 16'h5555);
        run_contention(2, 6'h12, 16'h7777, 6'h10, "tie_wr_last");
    endtask

    task automatic test_sustained();
        run_contention(8, 6'h20, 16'h4321, 6'h20, "sustained");
    endtask

    task automatic test_boundary();
        int cyc = 0;
        lone_write(6'h00, 16'h1111);
        lone_write(6'h3F, 16'hBEEF);
        rd_req = 1'b1; rd_addr = 6'h3F;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rd_grant && cyc < 10);
        checks++;
        if (!rd_grant || ram_addr !== 6'h3F) begin
            errors++;
            $display("FAIL bnd_addr: gnt=%b addr=%h expected 1 3f", rd_grant, ram_addr);
        end
        exp_q.push_back(model[6'h3F]);
        exp_last = OWN_RD;
        rd_req = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rd_valid && cyc < 10);
        checks++;
        if (!rd_valid || rd_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL bnd_data: valid=%b data=%h expected 1 beef", rd_valid, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        rd_req = 1'b1; rd_addr = 6'h05;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state_q !== RD_CAP) begin
            errors++;
            $display("FAIL mid_rd_setup: state=%0d expected RD_CAP", dut.state_q);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_grant, rd_grant, rd_valid, ram_we, ram_re} !== 5'b0 ||
            ram_addr !== '0 || ram_wdata !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_rd_outputs: strobes=%b addr=%h wd=%h rd=%h expected all 0",
                     {wr_grant, rd_grant, rd_valid, ram_we, ram_re},
                     ram_addr, ram_wdata, rd_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL mid_rd_state: state=%0d expected IDLE", dut.state_q);
        end
        reset = 1'b0;
        exp_last = OWN_RD;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_rd_novalid: rd_valid=%b expected 0", rd_valid);
            end
        end
        wr_req = 1'b1; wr_addr = 6'h2A; wr_data = 16'h9999;
        @(negedge clk);
        wr_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || wr_grant !== 1'b0) begin
            errors++;
            $display("FAIL mid_wr: we=%b gnt=%b expected 0 0", ram_we, wr_grant);
        end
        reset = 1'b0;
        exp_last = OWN_RD;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            model[i] = '0;
        end
        ram_rdata = '0;
        test_reset();
        test_write_only();
        test_read_after_write();
        test_tie();
        test_sustained();
        test_boundary();
        test_reset_mid_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
